// File: rtl/fft_stage_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_addr_gen_if
//  Purpose  : Issue bus between the FFT stage address sequencer and the
//             butterfly / memory read port.
//  Signals  : bf_valid      - issue fields below are valid
//             bf_ready      - downstream accepts the issue this cycle
//             addr_a/addr_b - memory addresses of butterfly inputs A and B
//             tw_idx        - twiddle ROM index (W_N^tw_idx)
//             stage         - current stage, 0 = span-1 stage
//             last_in_stage - final issue of the current stage
//  Modports : master (sequencer side), slave (butterfly side)
//  Revision : 1.0 - initial release
// ============================================================================
interface fft_stage_addr_gen_if #(
    parameter int N_LOG2 = 4
);
    localparam int C_STAGE_W = $clog2(N_LOG2);

    logic                  bf_valid;
    logic                  bf_ready;
    logic [N_LOG2-1:0]     addr_a;
    logic [N_LOG2-1:0]     addr_b;
    logic [N_LOG2-2:0]     tw_idx;
    logic [C_STAGE_W-1:0]  stage;
    logic                  last_in_stage;

    modport master (
        output bf_valid, addr_a, addr_b, tw_idx, stage, last_in_stage,
        input  bf_ready
    );

    modport slave (
        input  bf_valid, addr_a, addr_b, tw_idx, stage, last_in_stage,
        output bf_ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_addr_gen
//  Purpose  : Sequencer for an in-place radix-2 DIT FFT. For every butterfly
//             of every stage it issues the A/B memory addresses and the
//             twiddle ROM index, then idles PIPE_DEPTH cycles between stages
//             so the butterfly pipeline can finish writing back.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             start         - begin a full FFT (honoured only when idle)
//             bf            - issue bus (master modport)
//             busy          - FFT in progress
//             done          - one-cycle completion pulse
//             cycle_count   - RUN/DRAIN cycle counter (FFT_PERF_CNT_EN only)
//  Options  : define FFT_PERF_CNT_EN to add the 32-bit cycle_count output.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_stage_addr_gen #(
    parameter int N_LOG2     = 4,
    parameter int PIPE_DEPTH = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    fft_stage_addr_gen_if.master    bf,
    output logic                    busy,
    output logic                    done
`ifdef FFT_PERF_CNT_EN
    ,
    output logic [31:0]             cycle_count
`endif
);
    localparam int C_SW = $clog2(N_LOG2);
    localparam int C_KW = N_LOG2 - 1;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [C_KW-1:0]   kidx_t;
    typedef logic [C_SW-1:0]   sidx_t;

    localparam kidx_t      C_K_LAST = '1;                 // N/2 - 1
    localparam sidx_t      C_S_LAST = sidx_t'(N_LOG2 - 1);
    localparam logic [3:0] C_DRAIN  = 4'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    kidx_t      r_k;
    sidx_t      r_s;
    logic [3:0] r_drain;

    // span = 1 << s : distance between the A and B inputs of a butterfly
    function automatic addr_t f_span(input sidx_t s);
        return addr_t'(1) << s;
    endfunction

    // Insert a zero at bit s of k: the low s bits stay as the position inside
    // the group, the upper bits shift up one to skip over the B half.
    function automatic addr_t f_addr_a(input kidx_t k, input sidx_t s);
        addr_t kk;
        addr_t m;
        kk = addr_t'(k);
        m  = f_span(s) - addr_t'(1);
        return ((kk & ~m) << 1) | (kk & m);
    endfunction

    // pos << (N_LOG2-1-s). In the last stage span = N/2 overflows kidx_t to
    // zero, so span-1 wraps to all-ones, which is exactly the mask needed.
    function automatic kidx_t f_tw(input kidx_t k, input sidx_t s);
        kidx_t m;
        m = (kidx_t'(1) << s) - kidx_t'(1);
        return (k & m) << (C_S_LAST - s);
    endfunction

    kidx_t w_k_inc;
    sidx_t w_s_inc;
    addr_t w_inc_a;

    assign w_k_inc = r_k + 1'b1;
    assign w_s_inc = r_s + 1'b1;
    assign w_inc_a = f_addr_a(w_k_inc, r_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_k              <= '0;
            r_s              <= '0;
            r_drain          <= '0;
            bf.bf_valid      <= 1'b0;
            bf.addr_a        <= '0;
            bf.addr_b        <= '0;
            bf.tw_idx        <= '0;
            bf.stage         <= '0;
            bf.last_in_stage <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state          <= S_RUN;
                        r_k              <= '0;
                        r_s              <= '0;
                        busy             <= 1'b1;
                        bf.bf_valid      <= 1'b1;
                        bf.addr_a        <= '0;
                        bf.addr_b        <= addr_t'(1);
                        bf.tw_idx        <= '0;
                        bf.stage         <= '0;
                        bf.last_in_stage <= 1'b0;
                    end
                end
                S_RUN: begin
                    // bf_valid is held high for the whole of RUN, so ready
                    // alone decides acceptance; without it everything holds.
                    if (bf.bf_ready) begin
                        if (r_k == C_K_LAST) begin
                            r_state          <= S_DRAIN;
                            r_drain          <= C_DRAIN;
                            bf.bf_valid      <= 1'b0;
                            bf.last_in_stage <= 1'b0;
                        end else begin
                            r_k              <= w_k_inc;
                            bf.addr_a        <= w_inc_a;
                            bf.addr_b        <= w_inc_a | f_span(r_s);
                            bf.tw_idx        <= f_tw(w_k_inc, r_s);
                            bf.last_in_stage <= (w_k_inc == C_K_LAST);
                        end
                    end
                end
                S_DRAIN: begin
                    // Counter reaches zero on the PIPE_DEPTH-th drain cycle.
                    r_drain <= r_drain - 1'b1;
                    if (r_drain == 4'd1) begin
                        if (r_s == C_S_LAST) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state          <= S_RUN;
                            r_s              <= w_s_inc;
                            r_k              <= '0;
                            bf.bf_valid      <= 1'b1;
                            bf.addr_a        <= '0;
                            bf.addr_b        <= f_span(w_s_inc);
                            bf.tw_idx        <= '0;
                            bf.stage         <= w_s_inc;
                            bf.last_in_stage <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FFT_PERF_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cycles <= '0;
        end else if ((r_state == S_RUN || r_state == S_DRAIN) && r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycle_count = r_cycles;
`endif

endmodule
`default_nettype wire
